// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and its environment (lab-board
// controls on one side, the boolean function under exercise on the other).
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int NV = 1 << N_IN;

  logic            start;
  logic [NV-1:0]   expected;
  logic            func_out;
  logic [N_IN-1:0] func_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [NV-1:0]   captured;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_err_idx;

  modport slave (
    input  start, expected, func_out,
    output func_in, busy, done, pass, captured, err_count, first_err_idx
  );

  modport master (
    output start, expected, func_out,
    input  func_in, busy, done, pass, captured, err_count, first_err_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a combinational boolean function through every input vector, holds
// each for SETTLE cycles, samples it, and grades the result against a mask.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);
  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [N_IN-1:0] func_in_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [NV-1:0]   captured_q;
  logic [NV-1:0]   exp_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] first_q;

  logic            mism_d;
  logic            last_d;
  logic [N_IN:0]   err_d;
  logic [NV-1:0]   captured_d;

  // The error count can never legitimately exceed the vector count; the
  // clamp keeps the register honest regardless.
  function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
    if (v == (N_IN+1)'(NV)) return v;
    return v + {{N_IN{1'b0}}, 1'b1};
  endfunction

  always_comb begin
    mism_d     = (bus.func_out != exp_q[func_in_q]);
    last_d     = (func_in_q == N_IN'(NV - 1));
    err_d      = mism_d ? sat_inc(err_q) : err_q;
    captured_d = captured_q;
    captured_d[func_in_q] = bus.func_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      func_in_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      captured_q <= '0;
      exp_q      <= '0;
      err_q      <= '0;
      first_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q    <= S_SETTLE;
            func_in_q  <= '0;
            cnt_q      <= CW'(SETTLE - 1);
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= '0;
            exp_q      <= bus.expected;
            err_q      <= '0;
            first_q    <= '0;
          end
        end
        S_SETTLE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          captured_q <= captured_d;
          err_q      <= err_d;
          if (mism_d && (err_q == '0)) first_q <= func_in_q;
          if (last_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q   <= S_SETTLE;
            func_in_q <= func_in_q + 1'b1;
            cnt_q     <= CW'(SETTLE - 1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.func_in       = func_in_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.captured      = captured_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a reference grade of each sweep is
// queued when start is driven and compared when done rises.
module tb_truth_table_sweeper;
  localparam int N_IN   = 3;
  localparam int SETTLE = 2;
  localparam int SWEEP  = (1 << N_IN) * (SETTLE + 1);

  typedef struct packed {
    logic [7:0] cap;
    logic [3:0] ec;
    logic [2:0] fe;
    logic       ps;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  bit   stuck_sel;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(N_IN)) bus ();

  assign bus.func_out = stuck_sel ? 1'b0
                      : ((bus.func_in[2] & bus.func_in[1]) | bus.func_in[0]);

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t grade(input logic [7:0] mask, input bit stuck);
    exp_t r;
    logic [7:0] diff;
    logic [2:0] v;
    bit found;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      r.cap[i] = stuck ? 1'b0 : ((v[2] & v[1]) | v[0]);
    end
    diff = r.cap ^ mask;
    for (int i = 0; i < 8; i++) begin
      if (diff[i]) begin
        r.ec = r.ec + 4'd1;
        if (!found) begin
          r.fe  = 3'(i);
          found = 1'b1;
        end
      end
    end
    r.ps = (diff == 8'h00);
    return r;
  endfunction

  task automatic do_sweep(input logic [7:0] mask, input bit stuck, input bit hold_start, input int chg_cyc);
    exp_t e;
    int   k;
    bit   got;
    int   want;
    @(negedge clk);
    stuck_sel    = stuck;
    bus.expected = mask;
    bus.start    = 1'b1;
    sb.push_back(grade(mask, stuck));
    @(posedge clk); #1;
    chk("acc_busy", bus.busy, 1);
    chk("acc_done", bus.done, 0);
    chk("acc_err_clr", bus.err_count, 0);
    chk("acc_func_in", bus.func_in, 0);
    if (!hold_start) bus.start = 1'b0;
    got = 1'b0;
    k = 0;
    for (int c = 1; c <= SWEEP + 10; c++) begin
      @(posedge clk); #1;
      if (c == chg_cyc) bus.expected = 8'h00;
      if (bus.done) begin
        got = 1'b1;
        k   = c;
        break;
      end
      want = (c / (SETTLE + 1) > 7) ? 7 : c / (SETTLE + 1);
      chk("step_func_in", bus.func_in, want);
    end
    bus.start = 1'b0;
    chk("done_seen", got, 1);
    chk("done_latency", k, SWEEP);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("captured", bus.captured, e.cap);
      chk("err_count", bus.err_count, e.ec);
      if (e.ec != 0) chk("first_err_idx", bus.first_err_idx, e.fe);
      chk("pass", bus.pass, e.ps);
      chk("busy_end", bus.busy, 0);
      chk("func_in_end", bus.func_in, 7);
    end
    @(posedge clk); #1;
    chk("done_hold", bus.done, 1);
  endtask

  task automatic reset_mid_sweep();
    bit hit;
    @(negedge clk);
    stuck_sel    = 1'b0;
    bus.expected = 8'hEA;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.func_in == 3'd4) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rst_wait_fi4", hit, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_func_in", bus.func_in, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_captured", bus.captured, 0);
    chk("rst_err", bus.err_count, 0);
    chk("rst_first", bus.first_err_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle_busy", bus.busy, 0);
  endtask

  initial begin
    rst          = 1'b1;
    stuck_sel    = 1'b0;
    bus.start    = 1'b1;
    bus.expected = 8'hEA;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", bus.busy, 0);
    chk("init_done", bus.done, 0);
    chk("init_func_in", bus.func_in, 0);
    chk("init_captured", bus.captured, 0);
    chk("init_err", bus.err_count, 0);
    chk("init_pass", bus.pass, 0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", bus.busy, 0);

    do_sweep(8'hEA, 1'b0, 1'b0, 0);
    do_sweep(8'hEB, 1'b0, 1'b0, 0);
    do_sweep(8'h6A, 1'b0, 1'b0, 0);
    do_sweep(8'hEA, 1'b1, 1'b0, 0);
    do_sweep(8'hEA, 1'b0, 1'b0, 0);
    do_sweep(8'hEA, 1'b0, 1'b1, 10);
    reset_mid_sweep();
    do_sweep(8'hEA, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
